// File: rtl/sdram_port_arbiter.sv
// Shares the sdramburst host port between the CPU cache engine and the VGA line
// fetcher, one whole burst per grant, VGA first with a starvation guard for the CPU.
module sdram_port_arbiter #(
   parameter int HADDR_WIDTH    = 24,
   parameter int BURST_LEN      = 8,
   parameter int OFFSET_WIDTH   = 3,
   parameter int VGA_MAX_CONSEC = 3,
   parameter int TIMEOUT        = 255
) (
   input  logic                    clk1x,
   input  logic                    nrst,
   input  logic                    cpu_req,
   input  logic                    cpu_we,
   input  logic [HADDR_WIDTH-1:0]  cpu_addr,
   output logic                    cpu_grant,
   output logic                    cpu_beat,
   output logic                    cpu_done,
   input  logic                    vga_req,
   input  logic [HADDR_WIDTH-1:0]  vga_addr,
   output logic                    vga_grant,
   output logic                    vga_beat,
   output logic                    vga_done,
   output logic                    sd_rd,
   output logic                    sd_wr,
   output logic [HADDR_WIDTH-1:0]  sd_addr,
   input  logic                    sd_ready,
   input  logic                    sd_wr_beat,
   input  logic [OFFSET_WIDTH-1:0] sd_burst_offset,
   output logic                    timeout_err
);

   localparam int LOW_BITS = $clog2(BURST_LEN * 2);
   localparam int CONSEC_W = $clog2(VGA_MAX_CONSEC + 1);
   localparam int WD_W     = $clog2(TIMEOUT + 1);

   localparam logic [HADDR_WIDTH-1:0]  ADDR_MASK   = ~HADDR_WIDTH'((1 << LOW_BITS) - 1);
   localparam logic [OFFSET_WIDTH-1:0] LAST_OFFSET = OFFSET_WIDTH'(BURST_LEN - 1);
   localparam logic [CONSEC_W-1:0]     CONSEC_MAX  = CONSEC_W'(VGA_MAX_CONSEC);
   localparam logic [WD_W-1:0]         WD_LAST     = WD_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, ISSUE, BURST, DONE, GAP} state_t;

   state_t                state;
   state_t                state_nxt;
   logic                  owner_vga;
   logic                  is_write;
   logic [CONSEC_W-1:0]   vga_consec;
   logic [WD_W-1:0]       watchdog;
   logic                  grant_vga;
   logic                  grant_cpu;
   logic                  beat;
   logic                  last_beat;
   logic                  wd_expire;

   assign grant_vga = vga_req && (!cpu_req || (vga_consec < CONSEC_MAX));
   assign grant_cpu = !grant_vga && cpu_req;
   assign beat      = (state == BURST) && (is_write ? sd_wr_beat : sd_ready);
   assign last_beat = beat && (sd_burst_offset == LAST_OFFSET);
   // Abort on the idle cycle that would bring the watchdog up to TIMEOUT.
   assign wd_expire = (state == BURST) && !beat && (watchdog == WD_LAST);

   always_ff @(posedge clk1x or negedge nrst) begin
      if (!nrst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sd_rd     = 1'b0;
      sd_wr     = 1'b0;
      cpu_grant = 1'b0;
      vga_grant = 1'b0;
      cpu_done  = 1'b0;
      vga_done  = 1'b0;
      cpu_beat  = beat && !owner_vga;
      vga_beat  = beat && owner_vga;
      case (state)
         IDLE: begin
            if (grant_vga || grant_cpu) state_nxt = ISSUE;
         end
         ISSUE: begin
            state_nxt = BURST;
            sd_rd     = !is_write;
            sd_wr     = is_write;
            cpu_grant = !owner_vga;
            vga_grant = owner_vga;
         end
         BURST: begin
            if (last_beat || wd_expire) state_nxt = DONE;
            cpu_grant = !owner_vga;
            vga_grant = owner_vga;
         end
         DONE: begin
            state_nxt = GAP;
            cpu_grant = !owner_vga;
            vga_grant = owner_vga;
            cpu_done  = !owner_vga;
            vga_done  = owner_vga;
         end
         GAP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Owner, direction and address are captured once at grant and held for the burst.
   always_ff @(posedge clk1x or negedge nrst) begin
      if (!nrst) begin
         owner_vga   <= 1'b0;
         is_write    <= 1'b0;
         sd_addr     <= '0;
         vga_consec  <= '0;
         watchdog    <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state == IDLE && grant_vga) begin
            owner_vga <= 1'b1;
            is_write  <= 1'b0;
            sd_addr   <= vga_addr & ADDR_MASK;
            if (!cpu_req) begin
               vga_consec <= '0;
            end else if (vga_consec != CONSEC_MAX) begin
               vga_consec <= vga_consec + CONSEC_W'(1);
            end
         end else if (state == IDLE && grant_cpu) begin
            owner_vga  <= 1'b0;
            is_write   <= cpu_we;
            sd_addr    <= cpu_addr & ADDR_MASK;
            vga_consec <= '0;
         end
         if (state == ISSUE) begin
            watchdog <= '0;
         end else if (state == BURST) begin
            if (beat) begin
               watchdog <= '0;
            end else begin
               watchdog <= watchdog + WD_W'(1);
            end
         end
         if (wd_expire) timeout_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: directed bursts push expected issues
// and completions, a negedge monitor pops and compares them as the DUT shows them.
module tb_sdram_port_arbiter;

   typedef struct {
      logic        is_wr;
      logic [23:0] addr;
      logic        vga;
   } issue_t;

   typedef struct {
      logic vga;
      int   beats;
      logic terr;
   } done_t;

   logic        clk1x = 1'b0;
   logic        nrst;
   logic        cpu_req, cpu_we;
   logic [23:0] cpu_addr;
   logic        cpu_grant, cpu_beat, cpu_done;
   logic        vga_req;
   logic [23:0] vga_addr;
   logic        vga_grant, vga_beat, vga_done;
   logic        sd_rd, sd_wr;
   logic [23:0] sd_addr;
   logic        sd_ready, sd_wr_beat;
   logic [2:0]  sd_burst_offset;
   logic        timeout_err;

   int     checks = 0;
   int     errors = 0;
   int     cpu_beats = 0;
   int     vga_beats = 0;
   issue_t issue_q[$];
   done_t  done_q[$];

   sdram_port_arbiter dut (
      .clk1x(clk1x), .nrst(nrst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_grant(cpu_grant), .cpu_beat(cpu_beat), .cpu_done(cpu_done),
      .vga_req(vga_req), .vga_addr(vga_addr),
      .vga_grant(vga_grant), .vga_beat(vga_beat), .vga_done(vga_done),
      .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_addr(sd_addr),
      .sd_ready(sd_ready), .sd_wr_beat(sd_wr_beat), .sd_burst_offset(sd_burst_offset),
      .timeout_err(timeout_err)
   );

   always #5 clk1x = ~clk1x;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic apply_stimulus(input bit vga, input bit we, input logic [23:0] addr,
                                 input logic [23:0] exp_addr, input int exp_beats,
                                 input bit exp_terr, input bit exp_done);
      issue_t ie;
      done_t  de;
      ie.is_wr = we;
      ie.addr  = exp_addr;
      ie.vga   = vga;
      issue_q.push_back(ie);
      if (exp_done) begin
         de.vga   = vga;
         de.beats = exp_beats;
         de.terr  = exp_terr;
         done_q.push_back(de);
      end
      if (vga) begin
         vga_req  = 1'b1;
         vga_addr = addr;
      end else begin
         cpu_req  = 1'b1;
         cpu_we   = we;
         cpu_addr = addr;
      end
   endtask

   // Leaves the caller 1 time unit after the edge that entered ISSUE.
   task automatic wait_issue();
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk1x); #1;
         if (sd_rd || sd_wr) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("[TB] FAIL issue_wait: got no sd_rd/sd_wr, expected one within 40 cycles");
      end
   endtask

   // One beat per cycle from first to last; noise adds a wrong-kind strobe cycle between beats.
   task automatic drive_beats(input bit wr, input int first, input int last, input bit noise);
      for (int k = first; k <= last; k++) begin
         @(posedge clk1x); #1;
         sd_ready        = !wr;
         sd_wr_beat      = wr;
         sd_burst_offset = 3'(k);
         if (noise && k < 7) begin
            @(posedge clk1x); #1;
            sd_ready   = wr;
            sd_wr_beat = !wr;
         end
      end
      @(posedge clk1x); #1;
      sd_ready   = 1'b0;
      sd_wr_beat = 1'b0;
   endtask

   initial begin : monitor
      issue_t ie;
      done_t  de;
      forever begin
         @(negedge clk1x);
         if (!nrst) begin
            cpu_beats = 0;
            vga_beats = 0;
         end else begin
            if (cpu_beat) cpu_beats++;
            if (vga_beat) vga_beats++;
            if (sd_rd || sd_wr) begin
               if (issue_q.size() == 0) begin
                  check_output("unexpected_issue", 32'(sd_addr), 32'hFFFF_FFFF);
               end else begin
                  ie = issue_q.pop_front();
                  check_output("issue_sd_wr", 32'(sd_wr), 32'(ie.is_wr));
                  check_output("issue_sd_rd", 32'(sd_rd), 32'(!ie.is_wr));
                  check_output("issue_sd_addr", 32'(sd_addr), 32'(ie.addr));
                  check_output("issue_vga_grant", 32'(vga_grant), 32'(ie.vga));
                  check_output("issue_cpu_grant", 32'(cpu_grant), 32'(!ie.vga));
               end
            end
            if (cpu_done || vga_done) begin
               if (done_q.size() == 0) begin
                  check_output("unexpected_done", {cpu_done, vga_done}, 32'h0);
               end else begin
                  de = done_q.pop_front();
                  check_output("done_vga", 32'(vga_done), 32'(de.vga));
                  check_output("done_cpu", 32'(cpu_done), 32'(!de.vga));
                  check_output("done_beats", de.vga ? vga_beats : cpu_beats, de.beats);
                  check_output("done_timeout_err", 32'(timeout_err), 32'(de.terr));
               end
               cpu_beats = 0;
               vga_beats = 0;
            end
         end
      end
   end

   initial begin : watchdog_guard
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not end, expected completion");
      $fatal(1, "[TB] stuck");
   end

   initial begin : stimulus
      bit    seq_vga [8];
      int    n;
      nrst = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
      vga_req = 1'b0; vga_addr = '0;
      sd_ready = 1'b0; sd_wr_beat = 1'b0; sd_burst_offset = '0;
      seq_vga = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

      repeat (3) @(posedge clk1x);
      #1;
      check_output("rst_cpu_grant", cpu_grant, 0);
      check_output("rst_vga_grant", vga_grant, 0);
      check_output("rst_sd_rd", sd_rd, 0);
      check_output("rst_sd_wr", sd_wr, 0);
      check_output("rst_sd_addr", sd_addr, 0);
      check_output("rst_timeout_err", timeout_err, 0);
      check_output("rst_done", {cpu_done, vga_done}, 0);
      @(negedge clk1x);
      nrst = 1'b1;
      @(posedge clk1x); #1;

      $display("[TB] test 1: CPU fill");
      apply_stimulus(1'b0, 1'b0, 24'h012345, 24'h012340, 8, 1'b0, 1'b1);
      wait_issue();
      sd_ready        = 1'b1;
      sd_burst_offset = 3'd7;
      drive_beats(1'b0, 0, 7, 1'b0);
      cpu_req = 1'b0;
      repeat (2) @(posedge clk1x);
      #1;

      $display("[TB] test 2: CPU spill with stray read strobes");
      apply_stimulus(1'b0, 1'b1, 24'h00020F, 24'h000200, 8, 1'b0, 1'b1);
      wait_issue();
      drive_beats(1'b1, 0, 7, 1'b1);
      cpu_req = 1'b0;
      repeat (2) @(posedge clk1x);
      #1;

      $display("[TB] test 3: contention V,V,V,C,V,V,V,C");
      vga_addr = 24'h10001A;
      cpu_addr = 24'h200035;
      cpu_we   = 1'b0;
      vga_req  = 1'b1;
      cpu_req  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (seq_vga[i])
            apply_stimulus(1'b1, 1'b0, 24'h10001A, 24'h100010, 8, 1'b0, 1'b1);
         else
            apply_stimulus(1'b0, 1'b0, 24'h200035, 24'h200030, 8, 1'b0, 1'b1);
         wait_issue();
         drive_beats(1'b0, 0, 7, 1'b0);
      end
      vga_req = 1'b0;
      cpu_req = 1'b0;
      repeat (2) @(posedge clk1x);
      #1;

      $display("[TB] test 4: CPU request during VGA burst");
      apply_stimulus(1'b1, 1'b0, 24'h3000C4, 24'h3000C0, 8, 1'b0, 1'b1);
      wait_issue();
      @(posedge clk1x); #1;
      apply_stimulus(1'b0, 1'b1, 24'h00FFF8, 24'h00FFF0, 8, 1'b0, 1'b1);
      drive_beats(1'b0, 0, 7, 1'b0);
      vga_req = 1'b0;
      n = 0;
      for (int i = 1; i <= 10 && n == 0; i++) begin
         @(posedge clk1x); #1;
         if (sd_rd || sd_wr) n = i;
      end
      check_output("cpu_issue_after_vga_done", n, 3);
      drive_beats(1'b1, 0, 7, 1'b0);
      cpu_req = 1'b0;
      repeat (2) @(posedge clk1x);
      #1;

      $display("[TB] test 5: watchdog abort after offset 4");
      apply_stimulus(1'b0, 1'b0, 24'hABCDE7, 24'hABCDE0, 5, 1'b1, 1'b1);
      wait_issue();
      drive_beats(1'b0, 0, 4, 1'b0);
      n = 0;
      for (int i = 1; i <= 400 && n == 0; i++) begin
         @(posedge clk1x); #1;
         if (cpu_done) n = i;
      end
      check_output("timeout_idle_cycles", n, 255);
      cpu_req = 1'b0;
      repeat (3) @(posedge clk1x);
      #1;
      check_output("timeout_err_sticky", timeout_err, 1);

      $display("[TB] test 6: reset mid-burst");
      apply_stimulus(1'b0, 1'b0, 24'h0000F1, 24'h0000F0, 0, 1'b0, 1'b0);
      wait_issue();
      for (int k = 0; k <= 3; k++) begin
         @(posedge clk1x); #1;
         sd_ready        = 1'b1;
         sd_burst_offset = 3'(k);
      end
      #2 nrst = 1'b0;
      #1;
      check_output("midrst_cpu_grant", cpu_grant, 0);
      check_output("midrst_cpu_beat", cpu_beat, 0);
      check_output("midrst_sd_addr", sd_addr, 0);
      check_output("midrst_timeout_err", timeout_err, 0);
      check_output("midrst_strobes", {sd_rd, sd_wr, cpu_done, vga_done}, 0);
      sd_ready = 1'b0;
      cpu_req  = 1'b0;
      repeat (2) @(posedge clk1x);
      #3 nrst = 1'b1;
      repeat (20) @(posedge clk1x);
      #1;
      check_output("post_rst_cpu_grant", cpu_grant, 0);

      check_output("issue_queue_empty", issue_q.size(), 0);
      check_output("done_queue_empty", done_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
